// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS datapath: PC state encoding,
// instruction field positions and the datapath word width.
package mips_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned IMM_MSB    = 15;
   localparam int unsigned TARGET_MSB = 25;

   localparam logic [WORD_W-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      PC_RUN    = 2'b00,
      PC_HALTED = 2'b01,
      PC_FAULT  = 2'b10
   } pc_state_t;

   // Word-aligned, sign-extended branch displacement from the 16-bit immediate.
   function automatic logic [WORD_W-1:0] branch_offset(input logic [WORD_W-1:0] instr);
      return {{(WORD_W-IMM_MSB-3){instr[IMM_MSB]}}, instr[IMM_MSB:0], 2'b00};
   endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control/status bundle between the decode stage and the PC stage.
interface pc_unit_if
   import mips_pkg::*;
#(
   parameter int CNT_W = 32
);

   logic              en;
   logic [WORD_W-1:0] instr;
   logic              zero;
   logic              branch_eq;
   logic              branch_ne;
   logic              jump;
   logic              jump_reg;
   logic [WORD_W-1:0] rs_data;
   logic              halt;

   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] pc_plus4;
   logic              halted;
   logic              fault;
   logic [WORD_W-1:0] fault_addr;
   logic [CNT_W-1:0]  retired;

   modport master (
      output en, instr, zero, branch_eq, branch_ne, jump, jump_reg, rs_data, halt,
      input  pc, pc_plus4, halted, fault, fault_addr, retired
   );

   modport slave (
      input  en, instr, zero, branch_eq, branch_ne, jump, jump_reg, rs_data, halt,
      output pc, pc_plus4, halted, fault, fault_addr, retired
   );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: JR > J/JAL > taken branch > sequential.
module pc_next_logic
   import mips_pkg::*;
(
   input  logic [WORD_W-1:0] pc,
   input  logic [WORD_W-1:0] instr,
   input  logic              zero,
   input  logic              branch_eq,
   input  logic              branch_ne,
   input  logic              jump,
   input  logic              jump_reg,
   input  logic [WORD_W-1:0] rs_data,
   output logic [WORD_W-1:0] next_pc,
   output logic [WORD_W-1:0] pc_plus4
);

   logic              taken;
   logic [WORD_W-1:0] branch_target;
   logic [WORD_W-1:0] jump_target;
   logic              unused_opcode;

   assign unused_opcode = &{1'b0, instr[WORD_W-1:TARGET_MSB+1]};

   assign pc_plus4      = pc + PC_INC;
   assign taken         = (branch_eq & zero) | (branch_ne & ~zero);
   assign branch_target = pc_plus4 + branch_offset(instr);
   assign jump_target   = {pc_plus4[WORD_W-1:WORD_W-4], instr[TARGET_MSB:0], 2'b00};

   always_comb begin
      next_pc = pc_plus4;
      if (jump_reg)
         next_pc = rs_data;
      else if (jump)
         next_pc = jump_target;
      else if (taken)
         next_pc = branch_target;
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC register, RUN/HALTED/FAULT machine, instruction
// memory bounds trap and retired-instruction counter.
module pc_unit
   import mips_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                MEM_SIZE = 128,
   parameter int                CNT_W    = 32
) (
   input  logic      clock,
   input  logic      reset,
   pc_unit_if.slave  bus
);

   localparam logic [WORD_W-1:0] MEM_WORDS = WORD_W'(MEM_SIZE);

   pc_state_t         state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] fault_addr_q, fault_addr_d;
   logic [CNT_W-1:0]  retired_q, retired_d;

   logic [WORD_W-1:0] next_pc;
   logic [WORD_W-1:0] pc_plus4;
   logic [WORD_W-1:0] next_word;
   logic              bad_target;

   pc_next_logic u_next (
      .pc        (pc_q),
      .instr     (bus.instr),
      .zero      (bus.zero),
      .branch_eq (bus.branch_eq),
      .branch_ne (bus.branch_ne),
      .jump      (bus.jump),
      .jump_reg  (bus.jump_reg),
      .rs_data   (bus.rs_data),
      .next_pc   (next_pc),
      .pc_plus4  (pc_plus4)
   );

   assign next_word  = {2'b00, next_pc[WORD_W-1:2]};
   assign bad_target = (next_pc[1:0] != 2'b00) || (next_word >= MEM_WORDS);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fault_addr_d = fault_addr_q;
      retired_d    = retired_q;
      case (state_q)
         PC_RUN: begin
            // Halt wins over any redirect and skips the bounds check.
            if (bus.en) begin
               if (bus.halt) begin
                  state_d = PC_HALTED;
               end else if (bad_target) begin
                  fault_addr_d = next_pc;
                  state_d      = PC_FAULT;
               end else begin
                  pc_d      = next_pc;
                  retired_d = retired_q + CNT_W'(1);
               end
            end
         end
         PC_HALTED, PC_FAULT: ;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= PC_RUN;
         pc_q         <= RESET_PC;
         fault_addr_q <= '0;
         retired_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fault_addr_q <= fault_addr_d;
         retired_q    <= retired_d;
      end
   end

   assign bus.pc         = pc_q;
   assign bus.pc_plus4   = pc_plus4;
   assign bus.halted     = (state_q == PC_HALTED);
   assign bus.fault      = (state_q == PC_FAULT);
   assign bus.fault_addr = fault_addr_q;
   assign bus.retired    = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random control traffic, all
// checked against an address-level reference model.
module tb_pc_unit;
   import mips_pkg::*;

   localparam int MEM_SIZE = 128;
   localparam int CNT_W    = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   pc_unit_if #(.CNT_W(CNT_W)) bus ();

   pc_unit #(
      .RESET_PC (32'h0000_0000),
      .MEM_SIZE (MEM_SIZE),
      .CNT_W    (CNT_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference state: 0 = running, 1 = halted, 2 = faulted.
   int unsigned m_state = 0;
   logic [31:0] m_pc    = '0;
   logic [31:0] m_faddr = '0;
   logic [31:0] m_ret   = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_target();
      logic [31:0] seq;
      int          disp;
      seq = m_pc + 32'd4;
      if (bus.jump_reg) return bus.rs_data;
      if (bus.jump) return (seq & 32'hF000_0000) | ({6'd0, bus.instr[25:0]} * 32'd4);
      if ((bus.branch_eq && bus.zero) || (bus.branch_ne && !bus.zero)) begin
         disp = int'($signed(bus.instr[15:0])) * 4;
         return seq + 32'(disp);
      end
      return seq;
   endfunction

   task automatic idle();
      bus.en        = 1'b1;
      bus.instr     = '0;
      bus.zero      = 1'b0;
      bus.branch_eq = 1'b0;
      bus.branch_ne = 1'b0;
      bus.jump      = 1'b0;
      bus.jump_reg  = 1'b0;
      bus.rs_data   = '0;
      bus.halt      = 1'b0;
   endtask

   // Advance the model with the inputs currently driven, clock once, compare.
   task automatic tick();
      logic [31:0] nx;
      if (reset) begin
         m_state = 0; m_pc = '0; m_faddr = '0; m_ret = '0;
      end else if (m_state == 0 && bus.en) begin
         if (bus.halt) begin
            m_state = 1;
         end else begin
            nx = ref_target();
            if ((nx % 4) != 0 || (nx / 4) >= MEM_SIZE) begin
               m_faddr = nx;
               m_state = 2;
            end else begin
               m_pc  = nx;
               m_ret = m_ret + 32'd1;
            end
         end
      end
      @(posedge clock);
      #1;
      check_eq("pc", bus.pc, m_pc);
      check_eq("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
      check_eq("halted", {31'd0, bus.halted}, {31'd0, m_state == 1});
      check_eq("fault", {31'd0, bus.fault}, {31'd0, m_state == 2});
      check_eq("fault_addr", bus.fault_addr, m_faddr);
      check_eq("retired", bus.retired, m_ret);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Reset, then steer the PC to an aligned in-range address via JR.
   task automatic go_to(input logic [31:0] addr);
      do_reset();
      bus.jump_reg = 1'b1;
      bus.rs_data  = addr;
      tick();
      idle();
   endtask

   initial begin
      int unsigned stuck;
      logic [31:0] r;
      idle();

      // 1: sequential fetch from reset
      do_reset();
      check_eq("t1_pc0", bus.pc, 32'h0);
      check_eq("t1_ret0", bus.retired, 32'd0);
      tick(); check_eq("t1_pc4", bus.pc, 32'h4);
      tick(); check_eq("t1_pc8", bus.pc, 32'h8);
      tick(); check_eq("t1_pcC", bus.pc, 32'hC);
      check_eq("t1_ret3", bus.retired, 32'd3);

      // 2: branches
      go_to(32'h10);
      bus.branch_eq = 1'b1; bus.zero = 1'b1; bus.instr = 32'h0000_FFFC;
      tick(); check_eq("t2_beq_taken", bus.pc, 32'h04);
      go_to(32'h10);
      bus.branch_eq = 1'b1; bus.zero = 1'b0; bus.instr = 32'h0000_FFFC;
      tick(); check_eq("t2_beq_not", bus.pc, 32'h14);
      go_to(32'h10);
      bus.branch_ne = 1'b1; bus.zero = 1'b0; bus.instr = 32'h0000_0002;
      tick(); check_eq("t2_bne_taken", bus.pc, 32'h1C);

      // 3: jump and JR priority
      go_to(32'h8);
      bus.jump = 1'b1; bus.instr = 32'h0000_0010;
      tick(); check_eq("t3_jump", bus.pc, 32'h40);
      go_to(32'h8);
      bus.jump = 1'b1; bus.instr = 32'h0000_0010; bus.jump_reg = 1'b1; bus.rs_data = 32'h20;
      tick(); check_eq("t3_jr_prio", bus.pc, 32'h20);

      // 4: misaligned and out-of-range traps, then frozen
      go_to(32'h8);
      bus.jump_reg = 1'b1; bus.rs_data = 32'h22;
      tick();
      check_eq("t4_fault", {31'd0, bus.fault}, 32'd1);
      check_eq("t4_faddr", bus.fault_addr, 32'h22);
      check_eq("t4_pc_held", bus.pc, 32'h8);
      do_reset();
      bus.jump_reg = 1'b1; bus.rs_data = 32'h200;
      tick();
      check_eq("t4_faddr_oor", bus.fault_addr, 32'h200);
      bus.rs_data = 32'h40;
      for (int i = 0; i < 3; i++) tick();
      check_eq("t4_frozen_pc", bus.pc, 32'h0);
      check_eq("t4_frozen_ret", bus.retired, 32'd0);
      check_eq("t4_frozen_fa", bus.fault_addr, 32'h200);

      // 5: stall, then halt beating a jump
      do_reset();
      tick(); tick();
      bus.en = 1'b0; bus.jump = 1'b1; bus.instr = 32'h0000_0020;
      for (int i = 0; i < 4; i++) tick();
      check_eq("t5_stall_pc", bus.pc, 32'h8);
      check_eq("t5_stall_ret", bus.retired, 32'd2);
      bus.en = 1'b1; bus.halt = 1'b1;
      tick();
      check_eq("t5_halted", {31'd0, bus.halted}, 32'd1);
      check_eq("t5_halt_pc", bus.pc, 32'h8);
      idle();
      for (int i = 0; i < 5; i++) tick();
      check_eq("t5_still_halted", {31'd0, bus.halted}, 32'd1);
      check_eq("t5_halt_ret", bus.retired, 32'd2);

      // 6: reset out of HALTED, then out of FAULT
      do_reset();
      check_eq("t6_h_pc", bus.pc, 32'h0);
      check_eq("t6_h_ret", bus.retired, 32'd0);
      tick(); check_eq("t6_h_seq", bus.pc, 32'h4);
      bus.jump_reg = 1'b1; bus.rs_data = 32'h3;
      tick();
      idle();
      do_reset();
      check_eq("t6_f_fault", {31'd0, bus.fault}, 32'd0);
      check_eq("t6_f_faddr", bus.fault_addr, 32'h0);
      tick(); check_eq("t6_f_seq", bus.pc, 32'h4);

      // random traffic; a reset clears any sticky state after a few cycles
      stuck = 0;
      for (int i = 0; i < 600; i++) begin
         idle();
         reset         = ($urandom_range(0, 49) == 0) || (stuck > 3);
         bus.en        = ($urandom_range(0, 9) != 0);
         bus.halt      = ($urandom_range(0, 39) == 0);
         bus.zero      = $urandom_range(0, 1) == 1;
         bus.branch_eq = ($urandom_range(0, 4) == 0);
         bus.branch_ne = ($urandom_range(0, 4) == 0);
         bus.jump      = ($urandom_range(0, 9) == 0);
         bus.jump_reg  = ($urandom_range(0, 11) == 0);
         r             = $urandom;
         bus.instr     = r;
         if ($urandom_range(0, 3) != 0)
            bus.instr[25:0] = (bus.instr[15] ? 26'h3FF_FFF8 : 26'd0) | 26'($urandom_range(0, 7));
         bus.rs_data = ($urandom_range(0, 3) != 0) ? {23'd0, 7'($urandom_range(0, 127)), 2'b00}
                                                    : 32'($urandom);
         tick();
         stuck = (m_state != 0) ? stuck + 1 : 0;
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Program-counter stage of the single-cycle MIPS datapath. It sits directly upstream of the instruction memory and drives its byte address.
- Holds the PC register and computes the next PC from four sources: sequential, conditional branch, J/JAL target and JR register.
- Supports stall and halt.
- Traps any next address that is misaligned or beyond instruction-memory capacity.
- Exposes a retired-instruction counter for the testbench and debugging.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded on reset; must be word-aligned and below MEM_SIZE*4.
MEM_SIZE, 128, instruction-memory depth in 32-bit words; used for the bounds check.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  1 = advance; 0 = stall (all state held)
instr  input  32  current instruction from instruction memory (imm = [15:0], target = [25:0])
zero  input  1  ALU zero flag for the current instruction
branch_eq  input  1  current instruction is BEQ
branch_ne  input  1  current instruction is BNE
jump  input  1  current instruction is J/JAL
jump_reg  input  1  current instruction is JR
rs_data  input  32  register-file rs value (JR target)
halt  input  1  current instruction is the halt encoding
pc  output  32  current PC, wired to the instruction-memory address
pc_plus4  output  32  pc + 4 (JAL link value)
halted  output  1  block is in HALTED
fault  output  1  block is in FAULT
fault_addr  output  32  rejected next-PC value
retired  output  CNT_W  count of successful PC updates

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high and takes priority over everything else.
- Reset values: pc=RESET_PC, state=RUN, halted=0, fault=0, fault_addr=0, retired=0.
- States:
  - RUN (2'b00), HALTED (2'b01), FAULT (2'b10).
  - HALTED and FAULT are sticky; only reset leaves them.
- pc_plus4 = pc + 4, combinational, modulo 2^32.
- Branch:
  - taken = (branch_eq & zero) | (branch_ne & ~zero).
  - Target = pc_plus4 + (sign_extend(instr[15:0]) << 2), modulo 2^32.
- Jump target = {pc_plus4[31:28], instr[25:0], 2'b00}.
- next_pc priority: jump_reg (rs_data) > jump > taken branch > pc_plus4. Simultaneous select inputs resolve by this priority, with no error.
- Rising edge in RUN, evaluated in this order:
  1. en=0: hold pc, state and retired.
  2. halt=1: pc held, state→HALTED, retired unchanged. Halt beats any jump or branch in the same cycle, and no bounds check is done.
  3. next_pc[1:0]!=0 or next_pc[31:2] >= MEM_SIZE: pc held, fault_addr<=next_pc, state→FAULT.
  4. Otherwise: pc<=next_pc, retired<=retired+1 (wraps at 2^CNT_W).
- In HALTED or FAULT, all inputs except reset are ignored and pc, retired and fault_addr are frozen.
- Reset asserted mid-operation, including while en=0 or in HALTED/FAULT: the next edge restores all reset values.
- halted = (state==HALTED) and fault = (state==FAULT), both registered-state decodes with zero added latency.
- Latency: one cycle from control inputs to the new pc. pc is valid to instruction memory for the entire cycle.

Decomposition:
- Shared package (mips_pkg):
  - State encoding constants PC_RUN, PC_HALTED, PC_FAULT.
  - PC_INC=4.
  - Field positions IMM_MSB=15, TARGET_MSB=25.
  - The 32-bit word width.
- One sub-module, pc_next_logic: purely combinational. Takes pc, instr, zero, the select inputs and rs_data; produces next_pc and pc_plus4.
- pc_unit keeps the register, state machine, bounds check and counter.

Test Plan:
1. Reset then 3 cycles with en=1 and no controls → pc 0x0, 0x4, 0x8, 0xC; retired=3.
2. pc=0x10, branch_eq=1, zero=1, imm=16'hFFFC → pc=0x04. The same setup with zero=0 → pc=0x14. branch_ne=1, zero=0, imm=0x0002 → pc=0x1C.
3. pc=0x8, jump=1, instr[25:0]=26'h000_0010 → pc=0x40. With jump_reg=1 also asserted and rs_data=0x20 → pc=0x20 (JR priority).
4. jump_reg=1, rs_data=0x22 → fault=1, fault_addr=0x22, pc unchanged. Then rs_data=0x200 with MEM_SIZE=128 after reset → fault, fault_addr=0x200. Subsequent edges leave pc, retired and fault_addr frozen.
5. en=0 for 4 cycles mid-run → pc and retired unchanged. Then halt=1 together with jump=1 → halted=1, pc unchanged, retired unchanged, and it stays halted over 5 further cycles.
6. Assert reset while HALTED, and separately while FAULT → next edge gives pc=RESET_PC, halted=0, fault=0, fault_addr=0, retired=0. Normal sequencing then resumes (0x0, 0x4).
